// File: rtl/ram_lsu_pkg.sv
// Shared load/store decode: funct3 codes, FSM states and size/mask helpers.
// Pure declarations, no logic or timing of its own.
package ram_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } lsu_state_t;

  // Byte count from funct3[1:0]; the illegal code 11 is flagged elsewhere.
  function automatic logic [2:0] f3_size(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [2:0] nbytes);
    return 4'((5'd1 << nbytes) - 5'd1);
  endfunction

endpackage

// File: rtl/ram_lsu_if.sv
// CPU request/response and RAM port bundle of the load/store unit.
// slave = the LSU itself, master = CPU pipeline plus RAM as seen from outside.
interface ram_lsu_if #(
  parameter int SCALE = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic              mem_oe;
  logic [SCALE-1:0]  mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_we;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
           mem_oe, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           mem_oe, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/ram_lsu_extend.sv
// Sign/zero extension of right-aligned load data by funct3; combinational, no backpressure.
module lsu_extend
  import ram_lsu_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_funct3)
      F3_B:    o_data = {{24{i_data[7]}}, i_data[7:0]};
      F3_H:    o_data = {{16{i_data[15]}}, i_data[15:0]};
      F3_BU:   o_data = {24'h0, i_data[7:0]};
      F3_HU:   o_data = {16'h0, i_data[15:0]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/ram_lsu.sv
// RV32 load/store initiator for one RAM port; word-crossing accesses become two RAM accesses.
// Response 1 cycle after the last access (1 aligned, 2 split); req_ready drops only in SPLIT.
module ram_lsu
  import ram_lsu_pkg::*;
#(
  parameter int SCALE = 10
) (
  input logic      clk,
  input logic      rst,
  ram_lsu_if.slave bus
);

  lsu_state_t       r_state, w_next;
  logic [2:0]       r_f3, r_k;
  logic             r_store;
  logic [31:0]      r_wdata, r_p1;
  logic [SCALE-1:0] r_next_addr;
  logic             r_resp_valid, r_resp_err, r_resp_load, r_resp_split;

  logic [1:0]       w_off;
  logic [2:0]       w_n, w_k;
  logic             w_illegal, w_oor, w_err, w_split, w_accept;
  logic             w_mem_oe;
  logic [SCALE-1:0] w_mem_addr;
  logic [3:0]       w_mem_we, w_p1_mask;
  logic [31:0]      w_mem_wdata, w_raw, w_ext;

  assign w_off     = bus.req_addr[1:0];
  assign w_n       = f3_size(bus.req_funct3[1:0]);
  assign w_k       = 3'd4 - {1'b0, w_off};
  assign w_illegal = bus.req_store ? (bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11))
                                   : ((bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11));
  // The whole access is rejected even when only its second half leaves the RAM.
  assign w_oor     = (|bus.req_addr[31:SCALE]) ||
                     ((32'(bus.req_addr[SCALE-1:0]) + 32'(w_n) - 32'd1) >= (32'd1 << SCALE));
  assign w_err     = w_illegal || w_oor;
  assign w_split   = ({1'b0, w_off} + w_n) > 3'd4;
  assign w_accept  = bus.req_valid && (r_state == IDLE) && rst;

  always_comb begin
    w_next      = r_state;
    w_mem_oe    = 1'b0;
    w_mem_addr  = bus.req_addr[SCALE-1:0];
    w_mem_we    = 4'b0000;
    w_mem_wdata = bus.req_wdata;
    case (r_state)
      IDLE: begin
        if (w_accept && !w_err) begin
          w_mem_oe = 1'b1;
          w_mem_we = bus.req_store ? size_mask(w_split ? w_k : w_n) : 4'b0000;
          if (w_split) w_next = SPLIT;
        end
      end
      SPLIT: begin
        w_mem_oe    = 1'b1;
        w_mem_addr  = r_next_addr;
        w_mem_we    = r_store ? size_mask(f3_size(r_f3[1:0]) - r_k) : 4'b0000;
        w_mem_wdata = r_wdata >> {r_k, 3'b000};
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (!rst) begin
      w_mem_oe = 1'b0;
      w_mem_we = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_load  <= 1'b0;
      r_resp_split <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_resp_valid <= (w_accept && (w_err || !w_split)) || (r_state == SPLIT);
      r_resp_err   <= w_accept && w_err;
      r_resp_load  <= (w_accept && !w_err && !w_split && !bus.req_store) ||
                      ((r_state == SPLIT) && !r_store);
      r_resp_split <= (r_state == SPLIT);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_f3 <= bus.req_funct3;
    if (w_accept && w_split && !w_err) begin
      r_store     <= bus.req_store;
      r_wdata     <= bus.req_wdata;
      r_next_addr <= (bus.req_addr[SCALE-1:0] | SCALE'(3)) + SCALE'(1);
      r_k         <= w_k;
    end
    if (r_state == SPLIT) r_p1 <= bus.mem_rdata;
  end

  // Part-2 bytes sit above the k part-1 bytes captured during SPLIT.
  assign w_p1_mask = size_mask(r_k);
  assign w_raw = r_resp_split
               ? ((bus.mem_rdata << {r_k, 3'b000}) |
                  (r_p1 & {{8{w_p1_mask[3]}}, {8{w_p1_mask[2]}}, {8{w_p1_mask[1]}}, {8{w_p1_mask[0]}}}))
               : bus.mem_rdata;

  lsu_extend u_extend (
    .i_data   (w_raw),
    .i_funct3 (r_f3),
    .o_data   (w_ext)
  );

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_load ? w_ext : 32'h0;
  assign bus.mem_oe     = w_mem_oe;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_we     = w_mem_we;
  assign bus.mem_wdata  = w_mem_wdata;

endmodule

// File: tb/tb_ram_lsu.sv
// Bench for ram_lsu: byte-lane RAM model plus a flat byte-array reference of the load/store rules.
module tb_ram_lsu;
  localparam int SCALE     = 10;
  localparam int RAM_BYTES = 1 << SCALE;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_lsu_if #(.SCALE(SCALE)) bus ();
  ram_lsu #(.SCALE(SCALE)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] ram     [RAM_BYTES];
  logic [7:0] ref_mem [RAM_BYTES];
  int n_tests = 0;
  int n_fail  = 0;

  logic             cap_oe [4], cap_rdy [4], cap_rv [4], cap_rerr [4];
  logic [SCALE-1:0] cap_addr [4];
  logic [3:0]       cap_we [4];
  logic [31:0]      cap_wd [4], cap_rdat [4];

  // RAM: reads return bytes addr..end-of-word shifted down; writes land at addr+lane within the word.
  function automatic logic [31:0] ram_read(input logic [SCALE-1:0] a);
    logic [31:0] v;
    v = '0;
    for (int b = 0; b < 4; b++)
      if (b + int'(a[1:0]) < 4) v[8*b +: 8] = ram[int'(a) + b];
    return v;
  endfunction

  initial begin
    for (int i = 0; i < RAM_BYTES; i++) ram[i] = 8'(i * 37 + 11);
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus.mem_oe) begin
        bus.mem_rdata <= ram_read(bus.mem_addr);
        for (int b = 0; b < 4; b++)
          if (bus.mem_we[b] && (b + int'(bus.mem_addr[1:0]) < 4))
            ram[int'(bus.mem_addr) + b] <= bus.mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic model_apply(input logic st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output logic e_err, output logic e_split,
                             output logic [31:0] e_rdata);
    int n;
    logic legal;
    logic [31:0] v;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e_err = !legal || (longint'({32'h0, a}) + longint'(n) > longint'(RAM_BYTES));
    e_split = (int'(a[1:0]) + n) > 4;
    e_rdata = '0;
    if (!e_err) begin
      if (st) begin
        for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        e_rdata = v;
      end
    end
  endtask

  task automatic xfer(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin @(negedge clk); bus.req_valid = 1'b0; end
      #1;
      cap_oe[c] = bus.mem_oe; cap_addr[c] = bus.mem_addr; cap_we[c] = bus.mem_we;
      cap_wd[c] = bus.mem_wdata; cap_rdy[c] = bus.req_ready; cap_rv[c] = bus.resp_valid;
      cap_rerr[c] = bus.resp_err; cap_rdat[c] = bus.resp_rdata;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h0; bus.req_wdata = 32'hFFFF_FFFF;
    #1;
    n_tests++;
    if ({bus.mem_oe, bus.mem_we} !== 5'b0) begin
      n_fail++; $display("FAIL rst_gate: got %b, expected 00000", {bus.mem_oe, bus.mem_we});
    end
    @(negedge clk); #1;
    n_tests++;
    if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== 34'h0) begin
      n_fail++; $display("FAIL rst_resp: got %h, expected 0", {bus.resp_valid, bus.resp_err, bus.resp_rdata});
    end
    @(negedge clk);
    bus.req_valid = 1'b0; rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.req_ready, bus.mem_oe} !== 2'b10) begin
      n_fail++; $display("FAIL rst_ready: got %b, expected 10", {bus.req_ready, bus.mem_oe});
    end
  endtask

  task automatic test_aligned();
    logic e_err, e_split;
    logic [31:0] e_rd;
    model_apply(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, e_err, e_split, e_rd);
    xfer(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    n_tests++;
    if ({cap_oe[0], cap_addr[0], cap_we[0], cap_wd[0]} !== {1'b1, 10'h10, 4'hF, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL sw_issue: got %h, expected %h", {cap_oe[0], cap_addr[0], cap_we[0], cap_wd[0]},
                         {1'b1, 10'h10, 4'hF, 32'hDEAD_BEEF});
    end
    n_tests++;
    if ({cap_rv[1], cap_rerr[1], cap_rv[2]} !== 3'b100) begin
      n_fail++; $display("FAIL sw_resp: got %b, expected 100", {cap_rv[1], cap_rerr[1], cap_rv[2]});
    end
    xfer(1'b0, 3'b010, 32'h10, 32'h0);
    n_tests++;
    if ({cap_rv[1], cap_rerr[1], cap_rdat[1]} !== {2'b10, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL lw_resp: got %h, expected %h", {cap_rv[1], cap_rerr[1], cap_rdat[1]}, {2'b10, 32'hDEAD_BEEF});
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3s [4];
    logic [31:0] adr [4];
    logic [31:0] exps [4];
    f3s  = '{3'b000, 3'b100, 3'b001, 3'b101};
    adr  = '{32'h13, 32'h13, 32'h12, 32'h10};
    exps = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_BEEF};
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i < 4) begin
        bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_funct3 = f3s[i]; bus.req_addr = adr[i];
      end else begin
        bus.req_valid = 1'b0;
      end
      #1;
      if (i < 4) begin
        n_tests++;
        if (bus.req_ready !== 1'b1) begin
          n_fail++; $display("FAIL b2b_ready[%0d]: got %b, expected 1", i, bus.req_ready);
        end
      end
      if (i > 0) begin
        n_tests++;
        if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== {2'b10, exps[i-1]}) begin
          n_fail++; $display("FAIL b2b_resp[%0d]: got %h, expected %h", i - 1,
                             {bus.resp_valid, bus.resp_err, bus.resp_rdata}, {2'b10, exps[i-1]});
        end
      end
    end
    @(negedge clk); #1;
    n_tests++;
    if (bus.resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: got %b, expected 0", bus.resp_valid);
    end
  endtask

  task automatic test_split();
    logic e_err, e_split;
    logic [31:0] e_rd;
    model_apply(1'b1, 3'b010, 32'h14, 32'h0123_4567, e_err, e_split, e_rd);
    xfer(1'b1, 3'b010, 32'h14, 32'h0123_4567);
    xfer(1'b0, 3'b010, 32'h12, 32'h0);
    n_tests++;
    if ({cap_oe[0], cap_addr[0], cap_we[0], cap_oe[1], cap_addr[1], cap_rdy[1], cap_rv[1]} !==
        {1'b1, 10'h12, 4'h0, 1'b1, 10'h14, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL lw_split_issue: got %h", {cap_oe[0], cap_addr[0], cap_we[0], cap_oe[1], cap_addr[1], cap_rdy[1], cap_rv[1]});
    end
    n_tests++;
    if ({cap_rv[2], cap_rerr[2], cap_rdat[2], cap_rv[3]} !== {2'b10, 32'h4567_DEAD, 1'b0}) begin
      n_fail++; $display("FAIL lw_split_resp: got %h, expected %h", {cap_rv[2], cap_rerr[2], cap_rdat[2], cap_rv[3]},
                         {2'b10, 32'h4567_DEAD, 1'b0});
    end
    model_apply(1'b1, 3'b010, 32'h13, 32'hAABB_CCDD, e_err, e_split, e_rd);
    xfer(1'b1, 3'b010, 32'h13, 32'hAABB_CCDD);
    n_tests++;
    if ({cap_addr[0], cap_we[0], cap_wd[0], cap_addr[1], cap_we[1], cap_wd[1]} !==
        {10'h13, 4'b0001, 32'hAABB_CCDD, 10'h14, 4'b0111, 32'h00AA_BBCC}) begin
      n_fail++; $display("FAIL sw_split_issue: got %h", {cap_addr[0], cap_we[0], cap_wd[0], cap_addr[1], cap_we[1], cap_wd[1]});
    end
    n_tests++;
    if ({cap_rv[1], cap_rv[2], cap_rerr[2]} !== 3'b010) begin
      n_fail++; $display("FAIL sw_split_resp: got %b, expected 010", {cap_rv[1], cap_rv[2], cap_rerr[2]});
    end
    xfer(1'b0, 3'b010, 32'h10, 32'h0);
    n_tests++;
    if (cap_rdat[1] !== 32'hDDAD_BEEF) begin
      n_fail++; $display("FAIL sw_split_lo: got %h, expected ddadbeef", cap_rdat[1]);
    end
    xfer(1'b0, 3'b010, 32'h14, 32'h0);
    n_tests++;
    if (cap_rdat[1] !== 32'h01AA_BBCC) begin
      n_fail++; $display("FAIL sw_split_hi: got %h, expected 01aabbcc", cap_rdat[1]);
    end
    model_apply(1'b1, 3'b001, 32'h17, 32'h0000_1234, e_err, e_split, e_rd);
    xfer(1'b1, 3'b001, 32'h17, 32'h0000_1234);
    n_tests++;
    if ({cap_addr[0], cap_we[0], cap_oe[1], cap_addr[1], cap_we[1], cap_wd[1]} !==
        {10'h17, 4'b0001, 1'b1, 10'h18, 4'b0001, 32'h0000_0012}) begin
      n_fail++; $display("FAIL sh_split_issue: got %h", {cap_addr[0], cap_we[0], cap_oe[1], cap_addr[1], cap_we[1], cap_wd[1]});
    end
    xfer(1'b0, 3'b101, 32'h17, 32'h0);
    n_tests++;
    if ({cap_rv[2], cap_rdat[2]} !== {1'b1, 32'h0000_1234}) begin
      n_fail++; $display("FAIL lhu_split: got %h, expected 100001234", {cap_rv[2], cap_rdat[2]});
    end
  endtask

  task automatic test_errors();
    logic e_err, e_split;
    logic [31:0] e_rd;
    xfer(1'b0, 3'b010, 32'h3FE, 32'h0);
    n_tests++;
    if ({cap_rv[1], cap_rerr[1], cap_rdat[1], cap_oe[0], cap_oe[1], cap_oe[2]} !== {2'b11, 32'h0, 3'b000}) begin
      n_fail++; $display("FAIL lw_oor: got %h, expected %h", {cap_rv[1], cap_rerr[1], cap_rdat[1], cap_oe[0], cap_oe[1], cap_oe[2]},
                         {2'b11, 32'h0, 3'b000});
    end
    xfer(1'b0, 3'b011, 32'h20, 32'h0);
    n_tests++;
    if ({cap_rv[1], cap_rerr[1], cap_oe[0]} !== 3'b110) begin
      n_fail++; $display("FAIL ld_f3_011: got %b, expected 110", {cap_rv[1], cap_rerr[1], cap_oe[0]});
    end
    xfer(1'b1, 3'b101, 32'h20, 32'h0);
    n_tests++;
    if ({cap_rv[1], cap_rerr[1], cap_oe[0]} !== 3'b110) begin
      n_fail++; $display("FAIL st_f3_101: got %b, expected 110", {cap_rv[1], cap_rerr[1], cap_oe[0]});
    end
    model_apply(1'b0, 3'b000, 32'h3FF, 32'h0, e_err, e_split, e_rd);
    xfer(1'b0, 3'b000, 32'h3FF, 32'h0);
    n_tests++;
    if ({cap_rv[1], cap_rerr[1], cap_rdat[1]} !== {2'b10, e_rd}) begin
      n_fail++; $display("FAIL lb_top: got %h, expected %h", {cap_rv[1], cap_rerr[1], cap_rdat[1]}, {2'b10, e_rd});
    end
  endtask

  task automatic test_reset_split();
    logic e_err, e_split;
    logic [31:0] e_rd;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h21; bus.req_wdata = 32'h1122_3344;
    #1;
    n_tests++;
    if ({bus.mem_oe, bus.mem_addr, bus.mem_we} !== {1'b1, 10'h21, 4'b0111}) begin
      n_fail++; $display("FAIL rsplit_p1: got %h", {bus.mem_oe, bus.mem_addr, bus.mem_we});
    end
    for (int b = 0; b < 3; b++) ref_mem[32'h21 + b] = 8'(32'h1122_3344 >> (8 * b));
    @(negedge clk);
    bus.req_valid = 1'b0; rst = 1'b0;
    #1;
    n_tests++;
    if ({bus.mem_oe, bus.mem_we, bus.resp_valid} !== 6'b0) begin
      n_fail++; $display("FAIL rsplit_gate: got %b, expected 000000", {bus.mem_oe, bus.mem_we, bus.resp_valid});
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.req_ready, bus.resp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL rsplit_after: got %b, expected 10", {bus.req_ready, bus.resp_valid});
    end
    for (int w = 0; w < 2; w++) begin
      model_apply(1'b0, 3'b010, 32'h20 + 32'(4 * w), 32'h0, e_err, e_split, e_rd);
      xfer(1'b0, 3'b010, 32'h20 + 32'(4 * w), 32'h0);
      n_tests++;
      if ({cap_rv[1], cap_rdat[1]} !== {1'b1, e_rd}) begin
        n_fail++; $display("FAIL rsplit_mem[%0d]: got %h, expected %h", w, {cap_rv[1], cap_rdat[1]}, {1'b1, e_rd});
      end
    end
  endtask

  task automatic test_random();
    logic        st, e_err, e_split;
    logic [2:0]  f3;
    logic [31:0] a, wd, e_rd;
    int          n, k, lat;
    logic [2:0]  rv_exp;
    for (int it = 0; it < 300; it++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom;
      case ($urandom_range(0, 3))
        0: a = 32'($urandom_range(0, RAM_BYTES - 1));
        1: a = 32'($urandom_range(RAM_BYTES - 16, RAM_BYTES + 15));
        2: a = $urandom;
        default: a = 32'($urandom_range(0, 63));
      endcase
      n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      model_apply(st, f3, a, wd, e_err, e_split, e_rd);
      xfer(st, f3, a, wd);
      lat = (e_err || !e_split) ? 1 : 2;
      rv_exp = (lat == 1) ? 3'b100 : 3'b010;
      n_tests++;
      if ({cap_rv[1], cap_rv[2], cap_rv[3], cap_rerr[lat], cap_rdat[lat]} !== {rv_exp, e_err, e_rd}) begin
        n_fail++; $display("FAIL rnd_resp[%0d] st=%b f3=%0d a=%h: got %h, expected %h", it, st, f3, a,
                           {cap_rv[1], cap_rv[2], cap_rv[3], cap_rerr[lat], cap_rdat[lat]}, {rv_exp, e_err, e_rd});
      end
      n_tests++;
      if ({cap_oe[0], cap_oe[1], cap_oe[2]} !== (e_err ? 3'b000 : {1'b1, e_split, 1'b0})) begin
        n_fail++; $display("FAIL rnd_oe[%0d] a=%h: got %b", it, a, {cap_oe[0], cap_oe[1], cap_oe[2]});
      end
      if (!e_err) begin
        k = e_split ? 4 - int'(a[1:0]) : n;
        n_tests++;
        if ({cap_addr[0], cap_we[0]} !== {a[SCALE-1:0], (st ? 4'((1 << k) - 1) : 4'h0)}) begin
          n_fail++; $display("FAIL rnd_p1[%0d] a=%h: got %h", it, a, {cap_addr[0], cap_we[0]});
        end
        if (e_split) begin
          n_tests++;
          if ({cap_addr[1], cap_we[1], cap_wd[1]} !==
              {SCALE'((a & ~32'h3) + 32'h4), (st ? 4'((1 << (n - k)) - 1) : 4'h0), wd >> (8 * k)}) begin
            n_fail++; $display("FAIL rnd_p2[%0d] a=%h: got %h", it, a, {cap_addr[1], cap_we[1], cap_wd[1]});
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    for (int i = 0; i < RAM_BYTES; i++) ref_mem[i] = 8'(i * 37 + 11);
    test_reset();
    test_aligned();
    test_back_to_back();
    test_split();
    test_errors();
    test_reset_split();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_lsu.md
Name: ram_lsu

Overview:
- Load/store initiator that drives one port of the dual-port byte-lane RAM on behalf of the CPU pipeline.
- Accepts RV32 load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) and generates the RAM port signals oe/addr/wdata/we.
- Returns sign- or zero-extended load data.
- Splits any access crossing a 32-bit word boundary into two RAM-legal accesses, because the RAM only handles unaligned accesses that stay inside one word.

Parameters:
- SCALE, 10, RAM size is 2**SCALE bytes; must match the attached RAM and be >= 3.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid && req_ready
- req_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32 size/sign code
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse, for loads and stores
- resp_err  output  1  qualifies resp_valid; illegal funct3 or out-of-range address
- resp_rdata  output  32  extended load data; 0 for stores and errors
- mem_oe  output  1  RAM port enable
- mem_addr  output  SCALE  RAM byte address
- mem_wdata  output  32  RAM write data, unshifted (the RAM shifts it by addr[1:0])
- mem_we  output  4  RAM byte mask, unshifted (the RAM shifts it by addr[1:0])
- mem_rdata  input  32  RAM read data; valid the cycle after mem_oe, already shifted right by addr[1:0]

Behaviour:
- Reset (rst==0 at a clk edge):
  - state goes to IDLE; resp_valid=0, resp_err=0, resp_rdata=0.
  - While rst==0, mem_oe=0 and mem_we=0 (gated combinationally).
- Decode:
  - size n = 1/2/4 bytes for funct3[1:0] = 00/01/10.
  - Loads with funct3 011, 110 or 111 are illegal; stores with funct3[2]==1 or funct3[1:0]==11 are illegal.
  - off = addr[1:0].
  - Out of range: addr[31:SCALE]!=0, or addr+n-1 >= 2**SCALE.
  - Split when off+n > 4. This covers LH/SH at off 3 and LW/SW at off 1..3.
- req_ready = (state==IDLE).
- IDLE, accepted at cycle T, not split:
  - In T, combinationally: mem_oe=1, mem_addr=addr[SCALE-1:0], mem_we=(store ? low-n-bytes mask : 0), mem_wdata=wdata.
  - Stay in IDLE. resp_valid=1 at T+1.
  - For loads, resp_rdata = extend(mem_rdata low n bytes) in T+1, registered into the extend sub-module output path.
  - Back-to-back aligned requests therefore sustain one per cycle.
- IDLE, accepted at T, split (k = 4-off bytes in part 1, m = n-k bytes in part 2):
  - Part 1 in T: mem_addr=addr, mem_we=(store ? low-k mask : 0), mem_wdata=wdata.
  - Go to SPLIT and latch funct3, store, wdata, next-word address ((addr|3)+1) and k.
  - SPLIT (T+1): req_ready=0. Part 2 issued: mem_oe=1, mem_addr=next word (off 0), mem_we=(store ? low-m mask : 0), mem_wdata=wdata>>(8k).
  - SPLIT also captures the low k bytes of mem_rdata (part-1 data), then returns to IDLE.
  - T+2: resp_valid=1; load data = {part2 low m bytes, part1 low k bytes}, then extended.
- Error request (accepted at T):
  - No memory access (mem_oe=0 in T); the whole access is rejected, even if only the second half is out of range.
  - resp_valid=1 and resp_err=1 at T+1, resp_rdata=0.
- Extension: LB/LH sign-extend from bit 8n-1; LBU/LHU zero-extend; LW passes through.
- Generated masks never hit the RAM's unsupported cases: 0011 at off 3 and 1111 at off != 0 are never issued.
- When no request is accepted, mem_oe=0 and mem_we=0. resp_valid is high only the single cycle following completion.
- Reset during SPLIT: part 2 is not issued and no response is produced. A part-1 store may remain committed; this is accepted behaviour.

Decomposition:
- Shared package: funct3 constants (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101) and state encoding (IDLE, SPLIT).
- Shared helper: size-to-mask function.
- One sub-module, lsu_extend:
  - Inputs: data[31:0], funct3; output: 32-bit extended result.
  - Purely combinational, reused by the fetch/debug path.

Test Plan:
- SW 0x10 wdata 0xDEADBEEF at T -> T: mem_oe=1, mem_addr=0x10, mem_we=1111; T+1: resp_valid=1, resp_err=0. Then LW 0x10 -> T+1 resp_rdata=0xDEADBEEF.
- With 0x10=0xDEADBEEF: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF. Issue back-to-back: req_ready stays 1 and four consecutive resp_valid pulses appear.
- With 0x14=0x01234567: LW 0x12 -> T: addr 0x12, we 0000; T+1: addr 0x14, req_ready=0; T+2: resp_rdata=0x4567DEAD.
- SW 0x13 wdata 0xAABBCCDD -> part1: addr 0x13, we 0001, wdata 0xAABBCCDD; part2: addr 0x14, we 0111, wdata 0x00AABBCC. Then LW 0x10 -> 0xDDADBEEF; LW 0x14 -> 0x01AABBCC.
- SH 0x17 wdata 0x1234 -> part1: addr 0x17, we 0001; part2: addr 0x18, we 0001, wdata 0x00000012. Then LHU 0x17 -> 0x00001234.
- SCALE=10: LW 0x3FE -> resp_err=1 at T+1, mem_oe never asserted. Load funct3=011 -> resp_err=1. Split SW with rst=0 during SPLIT -> no part-2 access, no resp_valid, req_ready=1 after reset.
